irq_ctrl: RTL and testbench

Parametrised interrupt and trap controller placed between the `computer` peripheral sources and the CPU core. It replaces the single `intr`/`trap` pins with `NUM_IRQ` independently enabled sources, each edge- or level-triggered, plus one non-maskable trap. It prioritises pending events and presents one registered vector to the CPU through a request/acknowledge/end-of-interrupt handshake.

---
 rtl/irq_pkg.sv | 22 ++
 rtl/irq_prio_enc.sv | 25 ++
 rtl/irq_ctrl.sv | 137 +++++++++++++
 tb/tb_irq_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and helpers for the interrupt controller
//
// Contents:
//   irq_state_t  handshake FSM states
//   TRAP_VEC     vector number reserved for the non-maskable trap
//   irq_vec_of   maps maskable source index i to its vector number
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam int TRAP_VEC = 0;

  // Source i is presented to the CPU as vector i+1; vector 0 is the trap.
  function automatic int irq_vec_of(input int i);
    return i + 1;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - fixed-priority encoder, lowest index wins
//
// Ports:
//   req_i    N request lines, bit 0 has the highest priority
//   valid_o  at least one request line is set
//   vec_o    index of the highest-priority set line (0 when none)
module irq_prio_enc #(
  parameter int N = 9,
  parameter int W = 4
) (
  input  logic [N-1:0] req_i,
  output logic         valid_o,
  output logic [W-1:0] vec_o
);

  always_comb begin
    valid_o = |req_i;
    vec_o   = '0;
    // Scan from the top so the lowest set index is the last assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) vec_o = W'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - prioritised interrupt/trap controller with req/ack/eoi handshake
//
// Ports:
//   clock_50_b7a  system clock, rising edge
//   reset         synchronous active-high reset
//   irq_in        NUM_IRQ maskable source lines (synchronous)
//   trap          non-maskable trap, rising-edge triggered
//   en_we         enable register write strobe
//   en_wdata      new enable value, bit i enables source i
//   irq_req       vector presented to the CPU
//   irq_vec       presented vector: 0 = trap, i+1 = source i
//   irq_ack       CPU accepts the presented vector
//   eoi           CPU finished servicing
//   in_service    controller is in SERVICE
//   pending       bit 0 = trap, bit i+1 = source i (unmasked)
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int                   NUM_IRQ   = 8,
  parameter logic [NUM_IRQ-1:0]   EDGE_MASK = {NUM_IRQ{1'b1}},
  localparam int                  VEC_W     = $clog2(NUM_IRQ + 1)
) (
  input  logic               clock_50_b7a,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               trap,
  input  logic               en_we,
  input  logic [NUM_IRQ-1:0] en_wdata,
  output logic               irq_req,
  output logic [VEC_W-1:0]   irq_vec,
  input  logic               irq_ack,
  input  logic               eoi,
  output logic               in_service,
  output logic [NUM_IRQ:0]   pending
);

  irq_state_t         state_q;
  logic [NUM_IRQ-1:0] en_q;
  logic [NUM_IRQ-1:0] prev_q;
  logic               trap_prev_q;
  logic [NUM_IRQ:0]   pend_q, pend_d;
  logic               req_q, svc_q;
  logic [VEC_W-1:0]   vec_q;

  logic               ack_take;
  logic [NUM_IRQ:0]   elig;
  logic               win_valid;
  logic [VEC_W-1:0]   win_vec;

  assign ack_take = (state_q == REQ) && irq_ack;

  // Trap bypasses the enable register.
  assign elig = pend_q & {en_q, 1'b1};

  irq_prio_enc #(
    .N (NUM_IRQ + 1),
    .W (VEC_W)
  ) u_prio (
    .req_i   (elig),
    .valid_o (win_valid),
    .vec_o   (win_vec)
  );

  // A new edge takes precedence over the ack-clear of the same bit, so an
  // event coinciding with acceptance is not lost.
  always_comb begin
    pend_d = pend_q;
    if (trap && !trap_prev_q) begin
      pend_d[0] = 1'b1;
    end else if (ack_take && vec_q == VEC_W'(TRAP_VEC)) begin
      pend_d[0] = 1'b0;
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (EDGE_MASK[i]) begin
        if (irq_in[i] && !prev_q[i]) begin
          pend_d[i+1] = 1'b1;
        end else if (ack_take && vec_q == VEC_W'(irq_vec_of(i))) begin
          pend_d[i+1] = 1'b0;
        end
      end else begin
        pend_d[i+1] = irq_in[i];
      end
    end
  end

  always_ff @(posedge clock_50_b7a) begin
    if (reset) begin
      state_q     <= IDLE;
      en_q        <= '0;
      prev_q      <= '0;
      trap_prev_q <= 1'b0;
      pend_q      <= '0;
      req_q       <= 1'b0;
      svc_q       <= 1'b0;
      vec_q       <= '0;
    end else begin
      prev_q      <= irq_in;
      trap_prev_q <= trap;
      pend_q      <= pend_d;
      if (en_we) en_q <= en_wdata;

      case (state_q)
        IDLE: begin
          if (win_valid) begin
            state_q <= REQ;
            vec_q   <= win_vec;
            req_q   <= 1'b1;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state_q <= SERVICE;
            req_q   <= 1'b0;
            svc_q   <= 1'b1;
          end
        end
        SERVICE: begin
          if (eoi) begin
            state_q <= IDLE;
            svc_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          svc_q   <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req    = req_q;
  assign irq_vec    = vec_q;
  assign in_service = svc_q;
  assign pending    = pend_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed vector bench for irq_ctrl
module tb_irq_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] irq_in;
  logic         trap;
  logic         en_we;
  logic [N-1:0] en_wdata;
  logic         irq_req;
  logic [3:0]   irq_vec;
  logic         irq_ack;
  logic         eoi;
  logic         in_service;
  logic [N:0]   pending;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Source 4 is level-triggered, all others rising-edge.
  irq_ctrl #(
    .NUM_IRQ   (N),
    .EDGE_MASK (8'hEF)
  ) dut (
    .clock_50_b7a (clk),
    .reset        (reset),
    .irq_in       (irq_in),
    .trap         (trap),
    .en_we        (en_we),
    .en_wdata     (en_wdata),
    .irq_req      (irq_req),
    .irq_vec      (irq_vec),
    .irq_ack      (irq_ack),
    .eoi          (eoi),
    .in_service   (in_service),
    .pending      (pending)
  );

  typedef struct {
    logic         rst;
    logic [N-1:0] irq;
    logic         trp;
    logic         we;
    logic [N-1:0] wd;
    logic         ack;
    logic         e;
    logic         x_req;
    logic [3:0]   x_vec;
    logic         x_svc;
    logic [N:0]   x_pend;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [N-1:0] irq, input logic trp,
                     input logic we, input logic [N-1:0] wd, input logic ack,
                     input logic e, input logic x_req, input logic [3:0] x_vec,
                     input logic x_svc, input logic [N:0] x_pend);
    vec_t v;
    v.rst = rst; v.irq = irq; v.trp = trp; v.we = we; v.wd = wd;
    v.ack = ack; v.e = e; v.x_req = x_req; v.x_vec = x_vec;
    v.x_svc = x_svc; v.x_pend = x_pend;
    tbl.push_back(v);
  endtask

  // Drive one cycle of inputs, let the edge pass, then check the registered outputs.
  task automatic step(input string tag, input vec_t v);
    reset = v.rst; irq_in = v.irq; trap = v.trp; en_we = v.we;
    en_wdata = v.wd; irq_ack = v.ack; eoi = v.e;
    @(posedge clk);
    #1;
    total++;
    if (irq_req !== v.x_req) begin
      bad++; $display("FAIL %s irq_req got=%0b exp=%0b", tag, irq_req, v.x_req);
    end
    total++;
    if (irq_vec !== v.x_vec) begin
      bad++; $display("FAIL %s irq_vec got=%0d exp=%0d", tag, irq_vec, v.x_vec);
    end
    total++;
    if (in_service !== v.x_svc) begin
      bad++; $display("FAIL %s in_service got=%0b exp=%0b", tag, in_service, v.x_svc);
    end
    total++;
    if (pending !== v.x_pend) begin
      bad++; $display("FAIL %s pending got=%h exp=%h", tag, pending, v.x_pend);
    end
  endtask

  initial begin
    vec_t h;
    reset = 1'b1; irq_in = '0; trap = 1'b0; en_we = 1'b0;
    en_wdata = '0; irq_ack = 1'b0; eoi = 1'b0;

    //   rst irq    trp we wd     ack eoi | req vec svc pend
    // reset state
    add(1, 8'h00, 0, 0, 8'h00, 0, 0,   0, 0, 0, 9'h000);
    // single edge source 2, enabled in the same cycle as the pulse
    add(0, 8'h04, 0, 1, 8'h04, 0, 0,   0, 0, 0, 9'h008);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,   1, 3, 0, 9'h008);
    add(0, 8'h00, 0, 0, 8'h00, 1, 0,   0, 3, 1, 9'h000);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,   0, 3, 1, 9'h000);
    add(0, 8'h00, 0, 0, 8'h00, 0, 1,   0, 3, 0, 9'h000);
    // sources 1 and 5 together: vector 2 first, then 6
    add(0, 8'h00, 0, 1, 8'h22, 0, 0,   0, 3, 0, 9'h000);
    add(0, 8'h22, 0, 0, 8'h00, 0, 0,   0, 3, 0, 9'h044);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,   1, 2, 0, 9'h044);
    add(0, 8'h00, 0, 0, 8'h00, 1, 0,   0, 2, 1, 9'h040);
    add(0, 8'h00, 0, 0, 8'h00, 0, 1,   0, 2, 0, 9'h040);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,   1, 6, 0, 9'h040);
    add(0, 8'h00, 0, 0, 8'h00, 1, 0,   0, 6, 1, 9'h000);
    add(0, 8'h00, 0, 0, 8'h00, 0, 1,   0, 6, 0, 9'h000);
    // trap with all enables cleared
    add(0, 8'h00, 0, 1, 8'h00, 0, 0,   0, 6, 0, 9'h000);
    add(0, 8'h00, 1, 0, 8'h00, 0, 0,   0, 6, 0, 9'h001);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,   1, 0, 0, 9'h001);
    add(0, 8'h00, 0, 0, 8'h00, 1, 0,   0, 0, 1, 9'h000);
    add(0, 8'h00, 0, 0, 8'h00, 0, 1,   0, 0, 0, 9'h000);
    // trap during SERVICE of vector 3 waits for eoi
    add(0, 8'h00, 0, 1, 8'h04, 0, 0,   0, 0, 0, 9'h000);
    add(0, 8'h04, 0, 0, 8'h00, 0, 0,   0, 0, 0, 9'h008);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,   1, 3, 0, 9'h008);
    add(0, 8'h00, 0, 0, 8'h00, 1, 0,   0, 3, 1, 9'h000);
    add(0, 8'h00, 1, 0, 8'h00, 0, 0,   0, 3, 1, 9'h001);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,   0, 3, 1, 9'h001);
    add(0, 8'h00, 0, 0, 8'h00, 0, 1,   0, 3, 0, 9'h001);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,   1, 0, 0, 9'h001);
    add(0, 8'h00, 0, 0, 8'h00, 1, 0,   0, 0, 1, 9'h000);
    add(0, 8'h00, 0, 0, 8'h00, 0, 1,   0, 0, 0, 9'h000);
    // level source 4 held across ack and eoi re-requests
    add(0, 8'h00, 0, 1, 8'h10, 0, 0,   0, 0, 0, 9'h000);
    add(0, 8'h10, 0, 0, 8'h00, 0, 0,   0, 0, 0, 9'h020);
    add(0, 8'h10, 0, 0, 8'h00, 0, 0,   1, 5, 0, 9'h020);
    add(0, 8'h10, 0, 0, 8'h00, 1, 0,   0, 5, 1, 9'h020);
    add(0, 8'h10, 0, 0, 8'h00, 0, 1,   0, 5, 0, 9'h020);
    add(0, 8'h10, 0, 0, 8'h00, 0, 0,   1, 5, 0, 9'h020);
    add(0, 8'h00, 0, 0, 8'h00, 1, 0,   0, 5, 1, 9'h000);
    add(0, 8'h00, 0, 0, 8'h00, 0, 1,   0, 5, 0, 9'h000);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,   0, 5, 0, 9'h000);
    // edge on source 0 coincident with ack of vector 1: set wins
    add(0, 8'h00, 0, 1, 8'h01, 0, 0,   0, 5, 0, 9'h000);
    add(0, 8'h01, 0, 0, 8'h00, 0, 0,   0, 5, 0, 9'h002);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,   1, 1, 0, 9'h002);
    add(0, 8'h01, 0, 0, 8'h00, 1, 0,   0, 1, 1, 9'h002);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,   0, 1, 1, 9'h002);
    add(0, 8'h00, 0, 0, 8'h00, 0, 1,   0, 1, 0, 9'h002);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,   1, 1, 0, 9'h002);
    // reset while in REQ abandons the vector and clears enables
    add(1, 8'h00, 0, 0, 8'h00, 0, 0,   0, 0, 0, 9'h000);
    add(0, 8'h01, 0, 0, 8'h00, 0, 0,   0, 0, 0, 9'h002);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,   0, 0, 0, 9'h002);
    // enable write in the arbitration cycle: old (zero) enable is used
    add(0, 8'h00, 0, 1, 8'h01, 0, 0,   0, 0, 0, 9'h002);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0,   1, 1, 0, 9'h002);

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("row%0d", i), tbl[i]);
    end

    // Line held high through reset produces an edge right after reset;
    // ack and eoi in the wrong state are ignored.
    h = '{rst:1, irq:8'h01, trp:0, we:0, wd:8'h00, ack:0, e:0,
          x_req:0, x_vec:0, x_svc:0, x_pend:9'h000};
    step("hold_rst", h);
    h.rst = 0; h.ack = 1; h.e = 1; h.x_pend = 9'h002;
    step("hold_edge", h);
    h.ack = 0; h.e = 0;
    step("hold_stay", h);
    h.we = 1; h.wd = 8'h01;
    step("hold_en", h);
    h.we = 0; h.e = 1; h.x_req = 1; h.x_vec = 1;
    step("eoi_in_req", h);
    h.e = 0; h.ack = 1; h.x_req = 0; h.x_svc = 1; h.x_pend = 9'h000;
    step("ack_line_high", h);
    h.ack = 1; h.irq = 8'h00;
    step("ack_in_svc", h);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
